multi_clock_divider: RTL and testbench

- Parametrised successor to the single-channel divider: NUM_CH independent dividers, each with its own DIV_W-bit runtime divide value.
- Fully synchronous: every output is registered on clk_in; no combinational path from clk_in to any output.
- Adds per-channel enable, glitch-free divide changes at period boundaries, near-50% duty for odd divides, a one-cycle rise strobe, and a global phase-align strobe.
- Feeds the bit-pattern sequencer's timing enables.

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clock_div_channel.sv | 90 +++++++++
 rtl/multi_clock_divider.sv | 35 +++
 tb/tb_multi_clock_divider.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ==== clkdiv_pkg : shared constants, divide type and high-time helper | rev 1.0 ====
package clkdiv_pkg;

   localparam int DEF_DIV_W = 16;

   typedef logic [DEF_DIV_W-1:0] div_t;

   // High phase length for a divide of n: ceil(n/2), so odd divides lean high.
   function automatic logic [31:0] high_cnt(input logic [31:0] n);
      return n - (n >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/clock_div_channel.sv
`default_nettype none
// ==== clock_div_channel : one divider lane with enable, sync and boundary reload | rev 1.0 ====
module clock_div_channel
   import clkdiv_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic [DIV_W-1:0] div,
   input  logic             en,
   input  logic             sync,
   output logic             clk_out,
   output logic             rise,
   output logic             active
);

   logic             running_q, running_d;
   logic             pend_q, pend_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] act_div_q, act_div_d;
   logic             clk_q, clk_d;
   logic             rise_q, rise_d;
   logic             active_q, active_d;
   logic [DIV_W-1:0] high_w;

   assign high_w = DIV_W'(high_cnt(32'(act_div_q)));

   always_comb begin
      running_d = running_q;
      pend_d    = 1'b0;
      cnt_d     = cnt_q;
      act_div_d = act_div_q;
      clk_d     = clk_q;
      rise_d    = 1'b0;
      if (!en) begin
         running_d = 1'b0;
         cnt_d     = '0;
         clk_d     = 1'b0;
         act_div_d = div;
      end else if (!running_q || sync || (pend_q && act_div_q != '0)) begin
         // Start, phase realign, or first period after leaving a zero divide.
         running_d = 1'b1;
         act_div_d = div;
         cnt_d     = '0;
         clk_d     = (div != '0);
         rise_d    = (div != '0);
      end else if (act_div_q == '0) begin
         cnt_d     = '0;
         clk_d     = 1'b0;
         act_div_d = div;
         pend_d    = 1'b1;
      end else if (cnt_q == act_div_q - 1'b1) begin
         cnt_d     = '0;
         act_div_d = div;
         clk_d     = (div != '0);
         rise_d    = (div != '0);
      end else begin
         cnt_d = cnt_q + 1'b1;
         clk_d = ((cnt_q + 1'b1) < high_w);
      end
      active_d = running_d && (act_div_d != '0);
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         running_q <= 1'b0;
         pend_q    <= 1'b0;
         cnt_q     <= '0;
         act_div_q <= '0;
         clk_q     <= 1'b0;
         rise_q    <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         running_q <= running_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         act_div_q <= act_div_d;
         clk_q     <= clk_d;
         rise_q    <= rise_d;
         active_q  <= active_d;
      end
   end

   assign clk_out = clk_q;
   assign rise    = rise_q;
   assign active  = active_q;

endmodule
`default_nettype wire

// File: rtl/multi_clock_divider.sv
`default_nettype none
// ==== multi_clock_divider : NUM_CH independent registered clock dividers sharing one sync strobe | rev 1.0 ====
module multi_clock_divider
   import clkdiv_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = DEF_DIV_W
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic [NUM_CH*DIV_W-1:0] div,
   input  logic [NUM_CH-1:0]       en,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       rise,
   output logic [NUM_CH-1:0]       active
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      clock_div_channel #(
         .DIV_W (DIV_W)
      ) u_chan (
         .clk_in  (clk_in),
         .reset   (reset),
         .div     (div[c*DIV_W +: DIV_W]),
         .en      (en[c]),
         .sync    (sync),
         .clk_out (clk_out[c]),
         .rise    (rise[c]),
         .active  (active[c])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
`default_nettype none
// ==== tb_multi_clock_divider : directed vectors with queued expectations and a negedge monitor | rev 1.0 ====
module tb_multi_clock_divider;

   localparam int NUM_CH = 4;
   localparam int DIV_W  = 16;

   logic                    clk_in = 1'b0;
   logic                    reset;
   logic [NUM_CH*DIV_W-1:0] div;
   logic [NUM_CH-1:0]       en;
   logic                    sync;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       rise;
   logic [NUM_CH-1:0]       active;

   logic [11:0] exp_q[$];
   int          id_q[$];
   int          errors = 0;
   int          checks = 0;
   int          test_id = 0;

   always #5 clk_in = ~clk_in;

   multi_clock_divider #(
      .NUM_CH (NUM_CH),
      .DIV_W  (DIV_W)
   ) dut (
      .clk_in  (clk_in),
      .reset   (reset),
      .div     (div),
      .en      (en),
      .sync    (sync),
      .clk_out (clk_out),
      .rise    (rise),
      .active  (active)
   );

   always @(negedge clk_in) begin
      logic [11:0] e;
      int          id;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         id = id_q.pop_front();
         checks++;
         if (clk_out !== e[11:8]) begin
            errors++;
            $display("FAIL t%0d clk_out: got %b expected %b", id, clk_out, e[11:8]);
         end
         checks++;
         if (rise !== e[7:4]) begin
            errors++;
            $display("FAIL t%0d rise: got %b expected %b", id, rise, e[7:4]);
         end
         checks++;
         if (active !== e[3:0]) begin
            errors++;
            $display("FAIL t%0d active: got %b expected %b", id, active, e[3:0]);
         end
      end
   end

   task automatic tick(input logic [3:0] c, input logic [3:0] r, input logic [3:0] a);
      @(posedge clk_in);
      exp_q.push_back({c, r, a});
      id_q.push_back(test_id);
      #1;
   endtask

   task automatic set_div(input int ch, input logic [DIV_W-1:0] v);
      div[ch*DIV_W +: DIV_W] = v;
   endtask

   function automatic logic ph(input int k, input int n, input int h);
      return (k % n) < h;
   endfunction

   initial begin
      logic [8:0] c1v;
      logic [8:0] r1v;
      logic [8:0] a1v;
      logic       c;
      logic       r;
      int         j;

      // Reset held low, then idle with all channels disabled.
      test_id = 1;
      reset = 1'b0; en = '0; sync = 1'b0; div = '0;
      repeat (3) tick(4'b0, 4'b0, 4'b0);
      reset = 1'b1;
      repeat (2) tick(4'b0, 4'b0, 4'b0);

      // Even and odd divides side by side.
      test_id = 2;
      set_div(0, 16'd4); set_div(1, 16'd3); en = 4'b0011;
      for (int k = 0; k < 12; k++)
         tick({2'b0, ph(k, 3, 2), ph(k, 4, 2)}, {2'b0, ph(k, 3, 1), ph(k, 4, 1)}, 4'b0011);

      // Reset mid-period wins over enable.
      test_id = 3;
      set_div(0, 16'd5);
      reset = 1'b0;
      tick(4'b0, 4'b0, 4'b0);
      reset = 1'b1; en = 4'b0000;
      tick(4'b0, 4'b0, 4'b0);

      // Divide change only lands at the period boundary.
      test_id = 4;
      set_div(0, 16'd8); en = 4'b0001;
      for (int k = 0; k < 14; k++) begin
         if (k == 4) set_div(0, 16'd2);
         if (k < 8) begin
            c = (k < 4);
            r = (k == 0);
         end else begin
            c = ((k - 8) % 2 == 0);
            r = c;
         end
         tick({3'b0, c}, {3'b0, r}, 4'b0001);
      end
      en = 4'b0000;
      tick(4'b0, 4'b0, 4'b0);

      // Divide of 1 on ch0; ch1 starts at 0 then moves to 5.
      test_id = 5;
      c1v = 9'b100111000;
      r1v = 9'b100001000;
      a1v = 9'b111111100;
      set_div(0, 16'd1); set_div(1, 16'd0); en = 4'b0011;
      for (int k = 0; k < 9; k++) begin
         if (k == 2) set_div(1, 16'd5);
         tick({2'b0, c1v[k], 1'b1}, {2'b0, r1v[k], 1'b1}, {2'b0, a1v[k], 1'b1});
      end
      en = 4'b0000;
      tick(4'b0, 4'b0, 4'b0);

      // Sync realigns both running channels; disabled ch2 stays low.
      test_id = 6;
      set_div(0, 16'd6); set_div(1, 16'd4); set_div(2, 16'd3); en = 4'b0011;
      for (int k = 0; k < 13; k++) begin
         sync = (k == 7);
         j = (k < 7) ? k : k - 7;
         tick({2'b0, ph(j, 4, 2), ph(j, 6, 3)}, {2'b0, ph(j, 4, 1), ph(j, 6, 1)}, 4'b0011);
      end
      sync = 1'b0; en = 4'b0000;
      tick(4'b0, 4'b0, 4'b0);

      // Largest divide: 32768 high, 32767 low, next rise at 65535.
      test_id = 7;
      set_div(3, 16'hFFFF); en = 4'b1000;
      for (int k = 0; k <= 65536; k++) begin
         c = (k >= 65535) ? 1'b1 : (k < 32768);
         r = (k == 0) || (k == 65535);
         tick({c, 3'b0}, {r, 3'b0}, 4'b1000);
      end

      repeat (2) @(negedge clk_in);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
